ddr_cmd_sequencer: RTL and testbench

Initiator-side DRAM command generator for the DDR emulation flow. It accepts host read/write requests over a valid/ready handshake and turns them into single-cycle ACT/RD/WR/PR command pulses, with row/column addresses, for the DRAM timing emulator (`memtimingwrp`). It enforces tRCD, tRP, tCL and tWR with counters and keeps one row open between requests (open-page policy). It drives `dq` for writes, captures `dq` for reads, and returns read data on a response port.

---
 rtl/ddr_cmd_sequencer_if.sv | 34 +++
 rtl/ddr_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// ddr_cmd_sequencer_if
// Host-side request/response bundle of the DRAM command sequencer.
//   req_valid / req_ready : request handshake (host -> sequencer)
//   req_we                : 1 = write, 0 = read
//   req_row / req_col     : request row / column address
//   req_wdata             : write data
//   rsp_valid / rsp_rdata : one-cycle read-data response (sequencer -> host)
// master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface ddr_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ROW_W = 17,
  parameter int unsigned COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_row, req_col, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_row, req_col, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ddr_cmd_sequencer
// Initiator-side DRAM command generator with an open-page policy. Host
// requests are turned into single-cycle ACT/RD/WR/PR pulses that honour
// tRCD, tRP, tCL and tWR; write data is driven on dq, read data is captured
// from dq and returned on the response port.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   halt         : freeze; state holds, all pulses and rsp_valid are deferred
//   host         : request/response interface (slave side)
//   ACT/RD/WR/PR : one-cycle command pulses
//   row, column  : command address, held between pulses
//   dq, dq_oe    : bidirectional data bus and its output enable
// ---------------------------------------------------------------------------
module ddr_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ROWS  = 131072,
  parameter int unsigned COLS  = 1024,
  parameter int unsigned TRCD  = 3,
  parameter int unsigned TRP   = 3,
  parameter int unsigned TCL   = 2,
  parameter int unsigned TWR   = 2,
  localparam int unsigned ROW_W = $clog2(ROWS),
  localparam int unsigned COL_W = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  ddr_cmd_sequencer_if.slave   host,
  output logic                 ACT,
  output logic                 RD,
  output logic                 WR,
  output logic                 PR,
  output logic [ROW_W-1:0]     row,
  output logic [COL_W-1:0]     column,
  inout  wire  [WIDTH-1:0]     dq,
  output logic                 dq_oe
);

  localparam int unsigned CNT_MAX_A = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned CNT_MAX_B = (TCL > TWR) ? TCL : TWR;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  // Counters count down to zero; the reload value marks the first cycle of a wait state.
  localparam logic [CNT_W-1:0] CNT_TRCD = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] CNT_TRP  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] CNT_TCL  = CNT_W'(TCL - 1);
  localparam logic [CNT_W-1:0] CNT_TWR  = CNT_W'(TWR - 1);

  typedef enum logic [2:0] {
    StIdle,
    StOpen,
    StTrcdW,
    StCmd,
    StRdLat,
    StWrRec,
    StPreW
  } state_t;

  state_t           r_state;
  state_t           w_state_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  // Latched request
  logic             r_we;
  logic [ROW_W-1:0] r_req_row;
  logic [COL_W-1:0] r_req_col;
  logic [WIDTH-1:0] r_wdata;

  // r_row doubles as the open-row register: it only ever changes on ACT.
  logic [ROW_W-1:0] r_row;
  logic             r_row_vld;
  logic [COL_W-1:0] r_col;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rsp_valid;

  logic             w_ready;
  logic             w_accept;
  logic             w_hit;
  logic             w_load_row;
  logic             w_load_col;
  logic             w_sample;
  logic [ROW_W-1:0] w_row_d;
  logic [COL_W-1:0] w_col_d;

  assign w_ready  = ((r_state == StIdle) || (r_state == StOpen)) && !halt && !rst;
  assign w_accept = host.req_valid && w_ready;
  assign w_hit    = r_row_vld && (host.req_row == r_row);

  // Next-state logic. Under halt nothing advances, so every pending event
  // slips by exactly one cycle per halted cycle.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_load_row = 1'b0;
    w_load_col = 1'b0;
    w_sample   = 1'b0;
    w_row_d    = r_req_row;
    w_col_d    = r_req_col;
    if (!halt) begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_state_d  = StTrcdW;
            w_cnt_d    = CNT_TRCD;
            w_load_row = 1'b1;
            w_row_d    = host.req_row;
          end
        end
        StOpen: begin
          if (w_accept) begin
            if (w_hit) begin
              w_state_d  = StCmd;
              w_load_col = 1'b1;
              w_col_d    = host.req_col;
            end else begin
              w_state_d = StPreW;
              w_cnt_d   = CNT_TRP;
            end
          end
        end
        StPreW: begin
          if (r_cnt == '0) begin
            w_state_d  = StTrcdW;
            w_cnt_d    = CNT_TRCD;
            w_load_row = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StTrcdW: begin
          if (r_cnt == '0) begin
            w_state_d  = StCmd;
            w_load_col = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StCmd: begin
          if (r_we) begin
            w_state_d = StWrRec;
            w_cnt_d   = CNT_TWR;
          end else begin
            w_state_d = StRdLat;
            w_cnt_d   = CNT_TCL;
          end
        end
        StRdLat: begin
          // Last latency cycle: dq carries the read data at this edge.
          if (r_cnt == '0) begin
            w_state_d = StOpen;
            w_sample  = 1'b1;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        StWrRec: begin
          if (r_cnt == '0) begin
            w_state_d = StOpen;
          end else begin
            w_cnt_d = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_req_row   <= '0;
      r_req_col   <= '0;
      r_wdata     <= '0;
      r_row       <= '0;
      r_row_vld   <= 1'b0;
      r_col       <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
    end else if (!halt) begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_accept) begin
        r_we      <= host.req_we;
        r_req_row <= host.req_row;
        r_req_col <= host.req_col;
        r_wdata   <= host.req_wdata;
      end
      if (w_load_row) begin
        r_row     <= w_row_d;
        r_row_vld <= 1'b1;
      end
      if (w_load_col) begin
        r_col <= w_col_d;
      end
      if (w_sample) begin
        r_rdata <= dq;
      end
      // Held (not cleared) under halt so a pending response is deferred.
      r_rsp_valid <= w_sample;
    end
  end

  // Pulses decode from the first cycle of their state; halt masks them while
  // the state holds, which defers rather than drops them.
  always_comb begin
    ACT = 1'b0;
    PR  = 1'b0;
    RD  = 1'b0;
    WR  = 1'b0;
    if (!halt) begin
      ACT = (r_state == StTrcdW) && (r_cnt == CNT_TRCD);
      PR  = (r_state == StPreW) && (r_cnt == CNT_TRP);
      WR  = (r_state == StCmd) && r_we;
      RD  = (r_state == StCmd) && !r_we;
    end
    dq_oe = WR;
  end

  assign row            = r_row;
  assign column         = r_col;
  assign dq             = dq_oe ? r_wdata : {WIDTH{1'bz}};
  assign host.req_ready = w_ready;
  assign host.rsp_valid = r_rsp_valid && !halt;
  assign host.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ddr_cmd_sequencer
// Self-checking bench: a transaction-level reference model predicts, from the
// open-page rules and the timing parameters, in which active (non-halted)
// cycle each pulse, the response and req_ready must appear; every cycle of a
// transaction is compared. A small emulator stores WR data seen on the bus
// and returns it on dq after RD.
// ---------------------------------------------------------------------------
module tb_ddr_cmd_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned ROWS  = 131072;
  localparam int unsigned COLS  = 1024;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TCL  = 2;
  localparam int TWR  = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic halt = 1'b0;

  wire             ACT;
  wire             RD;
  wire             WR;
  wire             PR;
  wire [ROW_W-1:0] row;
  wire [COL_W-1:0] column;
  wire [WIDTH-1:0] dq;
  wire             dq_oe;

  logic             tb_oe = 1'b0;
  logic [WIDTH-1:0] tb_dq = '0;
  assign dq = tb_oe ? tb_dq : {WIDTH{1'bz}};

  ddr_cmd_sequencer_if #(.WIDTH(WIDTH), .ROW_W(ROW_W), .COL_W(COL_W)) host_if ();

  ddr_cmd_sequencer #(
    .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS),
    .TRCD(TRCD), .TRP(TRP), .TCL(TCL), .TWR(TWR)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt), .host(host_if),
    .ACT(ACT), .RD(RD), .WR(WR), .PR(PR),
    .row(row), .column(column), .dq(dq), .dq_oe(dq_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit               ref_vld = 1'b0;
  int               ref_row = 0;
  logic [WIDTH-1:0] ref_mem [int];
  logic [WIDTH-1:0] emu_mem [int];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // {ACT, RD, WR, PR, rsp_valid, req_ready, dq_oe}
  function automatic logic [31:0] outs();
    return 32'({ACT, RD, WR, PR, host_if.rsp_valid, host_if.req_ready, dq_oe});
  endfunction

  // One request; halts at absolute cycles [hstart, hstart+hlen) plus random
  // halts with probability hpct%. Returns cycles (relative to acceptance) at
  // which the DUT showed its RD/WR pulse and req_ready again, and read data.
  task automatic run_txn(input logic we, input int r, input int col, input logic [WIDTH-1:0] wd,
                         input int hstart, input int hlen, input int hpct,
                         output int cmd_cyc, output int ready_cyc,
                         output logic [WIDTH-1:0] rdata);
    int act_at, pr_at, cmd_at, end_at, a, c, w, k;
    logic [WIDTH-1:0] exp_rd;
    logic [31:0] exp;
    bit done;
    if (!ref_vld) begin
      pr_at = -1; act_at = 1; cmd_at = 1 + TRCD;
    end else if (ref_row == r) begin
      pr_at = -1; act_at = -1; cmd_at = 1;
    end else begin
      pr_at = 1; act_at = 1 + TRP; cmd_at = 1 + TRP + TRCD;
    end
    end_at = we ? cmd_at + TWR + 1 : cmd_at + TCL + 1;
    k = r * int'(COLS) + col;
    exp_rd = ref_mem.exists(k) ? ref_mem[k] : '0;

    @(posedge clk); #1;
    halt              = 1'b0;
    host_if.req_valid = 1'b1;
    host_if.req_we    = we;
    host_if.req_row   = ROW_W'(r);
    host_if.req_col   = COL_W'(col);
    host_if.req_wdata = wd;
    @(negedge clk);
    w = 0;
    while (!host_if.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!host_if.req_ready) check("accept_timeout", 32'(0), 32'(1));

    a = 0; c = 0; done = 1'b0;
    cmd_cyc = -1; ready_cyc = -1; rdata = '0;
    while (!done && c < 200) begin
      @(posedge clk); #1;
      c++;
      host_if.req_valid = 1'b0;
      halt = ((c >= hstart) && (c < hstart + hlen)) || (int'($urandom_range(99)) < hpct);
      @(negedge clk);
      if (halt) begin
        exp = '0;
      end else begin
        a++;
        exp = 32'({a == act_at, !we && a == cmd_at, we && a == cmd_at, a == pr_at,
                   !we && a == end_at, a == end_at, we && a == cmd_at});
      end
      check("pulses", outs(), exp);
      if (!halt && a == act_at) check("act_row", 32'(row), 32'(r));
      if (!halt && a == cmd_at) begin
        check("cmd_col", 32'(column), 32'(col));
        check("cmd_row", 32'(row), 32'(r));
        if (we) check("wr_dq", 32'(dq), 32'(wd));
      end
      // Emulator and observation, driven purely by what the DUT shows
      if (WR) emu_mem[int'(row) * int'(COLS) + int'(column)] = dq;
      if (RD) begin
        tb_dq = emu_mem.exists(int'(row) * int'(COLS) + int'(column)) ?
                emu_mem[int'(row) * int'(COLS) + int'(column)] : '0;
        tb_oe = 1'b1;
      end
      if ((RD || WR) && cmd_cyc < 0) cmd_cyc = c;
      if (host_if.req_ready && ready_cyc < 0) ready_cyc = c;
      if (host_if.rsp_valid) begin
        rdata = host_if.rsp_rdata;
        tb_oe = 1'b0;
      end
      if (!halt && a == end_at) done = 1'b1;
    end
    halt = 1'b0;
    if (!done) check("txn_timeout", 32'(0), 32'(1));
    if (!we) check("rsp_rdata", 32'(rdata), 32'(exp_rd));
    ref_vld = 1'b1;
    ref_row = r;
    if (we) ref_mem[k] = wd;
  endtask

  typedef struct {
    logic             we;
    int               r;
    int               col;
    logic [WIDTH-1:0] wd;
    int               end_c;
    logic [WIDTH-1:0] rd;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int cc, rc, w;
    logic [WIDTH-1:0] rd;

    tbl[0]  = '{1'b1, 0, 1, 4'd2, 7,  4'd0};  // cold write
    tbl[1]  = '{1'b0, 0, 1, 4'd0, 4,  4'd2};  // read hit
    tbl[2]  = '{1'b0, 1, 4, 4'd0, 10, 4'd0};  // read miss
    tbl[3]  = '{1'b1, 0, 0, 4'd2, 10, 4'd0};
    tbl[4]  = '{1'b1, 1, 1, 4'd5, 10, 4'd0};
    tbl[5]  = '{1'b1, 0, 2, 4'd8, 10, 4'd0};
    tbl[6]  = '{1'b1, 1, 3, 4'd1, 10, 4'd0};
    tbl[7]  = '{1'b1, 0, 4, 4'd4, 10, 4'd0};
    tbl[8]  = '{1'b1, 1, 5, 4'd7, 10, 4'd0};
    tbl[9]  = '{1'b0, 0, 0, 4'd0, 10, 4'd2};
    tbl[10] = '{1'b0, 1, 1, 4'd0, 10, 4'd5};
    tbl[11] = '{1'b0, 0, 2, 4'd0, 10, 4'd8};
    tbl[12] = '{1'b0, 1, 3, 4'd0, 10, 4'd1};
    tbl[13] = '{1'b0, 0, 4, 4'd0, 10, 4'd4};
    tbl[14] = '{1'b0, 1, 5, 4'd0, 10, 4'd7};

    host_if.req_valid = 1'b0;
    host_if.req_we    = 1'b0;
    host_if.req_row   = '0;
    host_if.req_col   = '0;
    host_if.req_wdata = '0;

    // Reset held two cycles: everything zero, req_ready low while rst is high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", outs(), 32'(0));
    check("rst_row", 32'(row), 32'(0));
    check("rst_col", 32'(column), 32'(0));
    check("rst_rdata", 32'(host_if.rsp_rdata), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", outs(), 32'(7'b0000010));

    // Directed table
    for (int i = 0; i < 15; i++) begin
      run_txn(tbl[i].we, tbl[i].r, tbl[i].col, tbl[i].wd, 0, 0, 0, cc, rc, rd);
      check($sformatf("tbl%0d_ready_cyc", i), 32'(rc), 32'(tbl[i].end_c));
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
    end

    // Halt for 3 cycles right after ACT of a read miss (row 1 open -> row 0)
    run_txn(1'b0, 0, 2, 4'd0, 5, 3, 0, cc, rc, rd);
    check("halt_rd_cyc", 32'(cc), 32'(10));
    check("halt_ready_cyc", 32'(rc), 32'(13));
    check("halt_rdata", 32'(rd), 32'(8));

    // Request held during halt must not be accepted
    @(posedge clk); #1;
    halt              = 1'b1;
    host_if.req_valid = 1'b1;
    host_if.req_we    = 1'b0;
    host_if.req_row   = ROW_W'(1);
    host_if.req_col   = COL_W'(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_no_accept", outs(), 32'(0));
      @(posedge clk); #1;
    end
    run_txn(1'b0, 1, 1, 4'd0, 0, 0, 0, cc, rc, rd);
    check("after_halt_rdata", 32'(rd), 32'(5));

    // Randomized traffic with random halts
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(7)),
              WIDTH'($urandom), 0, 0, 15, cc, rc, rd);
    end

    // Reset during RDLAT of a read hit: no response, fresh ACT afterwards
    @(posedge clk); #1;
    host_if.req_valid = 1'b1;
    host_if.req_we    = 1'b0;
    host_if.req_row   = ROW_W'(ref_row);
    host_if.req_col   = COL_W'(0);
    @(negedge clk);
    w = 0;
    while (!host_if.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!host_if.req_ready) check("rst_seq_accept_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    host_if.req_valid = 1'b0;
    @(negedge clk);
    check("rst_seq_rd", 32'(RD), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rdlat_rst_outs", outs(), 32'(0));
    check("rdlat_rst_row", 32'(row), 32'(0));
    check("rdlat_rst_col", 32'(column), 32'(0));
    check("rdlat_rst_rdata", 32'(host_if.rsp_rdata), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    tb_oe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rdlat_rst_idle", outs(), 32'(7'b0000010));
      @(posedge clk); #1;
    end
    ref_vld = 1'b0;
    run_txn(1'b0, ref_row, 0, 4'd0, 0, 0, 0, cc, rc, rd);
    check("post_rst_ready_cyc", 32'(rc), 32'(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
